// File: rtl/trace_buffer_pkg.sv
// Shared geometry and entry format for the double-buffered column store
// that sits between the ray tracer and the VGA renderer.
package trace_buffer_pkg;

  localparam int COLS   = 640;
  localparam int CENTRE = 240;
  localparam int HW     = 8;
  localparam int COL_W  = 10;
  localparam int ROW_W  = 10;

  localparam logic [COL_W-1:0] COLS_IDX = COL_W'(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W:0]   CENTRE_W = (ROW_W + 1)'(CENTRE);

  typedef struct packed {
    logic          side;
    logic [HW-1:0] height;
  } entry_t;

endpackage

// File: rtl/trace_bank.sv
// One bank of column entries: a plain synchronous-write, synchronous-read RAM.
module trace_bank
  import trace_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [COL_W-1:0] waddr_i,
  input  entry_t           wdata_i,
  input  logic [COL_W-1:0] raddr_i,
  output entry_t           rdata_o
);

  entry_t mem [COLS];
  entry_t rdata_q;

  // Contents are deliberately left unreset; validity is tracked by the parent.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_buffer.sv
// Ping-pong column store: tracer fills the back bank, renderer reads the
// front bank, and banks swap at frame boundaries only for complete frames.
module trace_buffer
  import trace_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] wr_col_i,
  input  logic             wr_side_i,
  input  logic [HW-1:0]    wr_height_i,
  input  logic             frame_swap_i,
  input  logic [COL_W-1:0] rd_col_i,
  input  logic [ROW_W-1:0] rd_row_i,
  output logic             rd_side_o,
  output logic [HW-1:0]    rd_height_o,
  output logic             rd_wall_o,
  output logic             front_bank_o,
  output logic             frame_valid_o,
  output logic [7:0]       dropped_frames_o
);

  logic             front_q, front_d;
  logic             valid_q, valid_d;
  logic [7:0]       dropped_q, dropped_d;
  logic [COL_W-1:0] expected_q, expected_d;
  logic             complete_q, complete_d;
  logic             seq_err_q, seq_err_d;

  logic             rd_ok_q;
  logic             rd_sel_q;
  logic [ROW_W-1:0] row_q;

  logic   wr_in_range;
  entry_t wdata;
  entry_t rdata0, rdata1, rdata;

  assign wr_in_range = wr_col_i < COLS_IDX;
  assign wdata       = '{side: wr_side_i, height: wr_height_i};

  // The back bank is whichever one is not on screen this cycle.
  trace_bank u_bank0 (
    .clk     (clk),
    .we_i    (wr_en_i && wr_in_range && front_q),
    .waddr_i (wr_col_i),
    .wdata_i (wdata),
    .raddr_i (rd_col_i),
    .rdata_o (rdata0)
  );

  trace_bank u_bank1 (
    .clk     (clk),
    .we_i    (wr_en_i && wr_in_range && !front_q),
    .waddr_i (wr_col_i),
    .wdata_i (wdata),
    .raddr_i (rd_col_i),
    .rdata_o (rdata1)
  );

  // Sequence tracking first, so a same-cycle final write can complete the frame
  // that the swap then accepts.
  always_comb begin
    front_d    = front_q;
    valid_d    = valid_q;
    dropped_d  = dropped_q;
    expected_d = expected_q;
    complete_d = complete_q;
    seq_err_d  = seq_err_q;

    if (wr_en_i) begin
      if (wr_in_range) begin
        if (wr_col_i != expected_q) seq_err_d = 1'b1;
        if (wr_col_i == LAST_COL && !seq_err_q && wr_col_i == expected_q)
          complete_d = 1'b1;
        expected_d = wr_col_i + COL_W'(1);
      end else begin
        seq_err_d = 1'b1;
      end
    end

    if (frame_swap_i) begin
      if (complete_d) begin
        front_d = ~front_q;
        valid_d = 1'b1;
      end else if (dropped_q != 8'hFF) begin
        dropped_d = dropped_q + 8'd1;
      end
      complete_d = 1'b0;
      seq_err_d  = 1'b0;
      expected_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q    <= 1'b0;
      valid_q    <= 1'b0;
      dropped_q  <= '0;
      expected_q <= '0;
      complete_q <= 1'b0;
      seq_err_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      row_q      <= '0;
    end else begin
      front_q    <= front_d;
      valid_q    <= valid_d;
      dropped_q  <= dropped_d;
      expected_q <= expected_d;
      complete_q <= complete_d;
      seq_err_q  <= seq_err_d;
      rd_ok_q    <= valid_q && (rd_col_i < COLS_IDX);
      rd_sel_q   <= front_q;
      row_q      <= rd_row_i;
    end
  end

  // Bank choice and validity are captured alongside the RAM read so a swap
  // never mixes old address with new bank.
  assign rdata       = rd_sel_q ? rdata1 : rdata0;
  assign rd_side_o   = rd_ok_q && rdata.side;
  assign rd_height_o = rd_ok_q ? rdata.height : '0;

  logic [ROW_W:0] row_w, h_w;
  assign row_w     = {1'b0, row_q};
  assign h_w       = (ROW_W + 1)'(rd_height_o);
  assign rd_wall_o = rd_ok_q && (h_w != '0) &&
                     (row_w + h_w >= CENTRE_W) && (row_w < CENTRE_W + h_w);

  assign front_bank_o     = front_q;
  assign frame_valid_o    = valid_q;
  assign dropped_frames_o = dropped_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer: swap acceptance/refusal,
// registered read path and the per-pixel wall window.
module tb_trace_buffer;
  import trace_buffer_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic             wr_side;
  logic [HW-1:0]    wr_height;
  logic             frame_swap;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic             rd_side;
  logic [HW-1:0]    rd_height;
  logic             rd_wall;
  logic             front_bank;
  logic             frame_valid;
  logic [7:0]       dropped_frames;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  trace_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .wr_en_i          (wr_en),
    .wr_col_i         (wr_col),
    .wr_side_i        (wr_side),
    .wr_height_i      (wr_height),
    .frame_swap_i     (frame_swap),
    .rd_col_i         (rd_col),
    .rd_row_i         (rd_row),
    .rd_side_o        (rd_side),
    .rd_height_o      (rd_height),
    .rd_wall_o        (rd_wall),
    .front_bank_o     (front_bank),
    .frame_valid_o    (frame_valid),
    .dropped_frames_o (dropped_frames)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Writes columns first..last in order with height (c+ofs)%241, skipping one.
  task automatic applyStimulus(input int first, input int last, input int skip,
                               input int ofs);
    for (int c = first; c <= last; c++) begin
      if (c != skip) begin
        wr_en     = 1'b1;
        wr_col    = COL_W'(c);
        wr_side   = c[0];
        wr_height = HW'((c + ofs) % 241);
        step();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic pulseSwap();
    frame_swap = 1'b1;
    step();
    frame_swap = 1'b0;
  endtask

  task automatic readAt(input int col, input int row);
    rd_col = COL_W'(col);
    rd_row = ROW_W'(row);
    step();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_col = '0; wr_side = 1'b0; wr_height = '0;
    frame_swap = 1'b0; rd_col = '0; rd_row = '0;
    step(); step();
    reset = 1'b0;

    checkOutput("reset_front", front_bank, 0);
    checkOutput("reset_valid", frame_valid, 0);
    checkOutput("reset_dropped", dropped_frames, 0);
    readAt(5, 240);
    checkOutput("reset_rd_height", rd_height, 0);
    checkOutput("reset_rd_side", rd_side, 0);
    checkOutput("reset_rd_wall", rd_wall, 0);

    $display("[TB] full in-order frame then swap");
    applyStimulus(0, 639, -1, 0);
    pulseSwap();
    checkOutput("swap1_front", front_bank, 1);
    checkOutput("swap1_valid", frame_valid, 1);
    readAt(100, 0);
    checkOutput("swap1_h100", rd_height, 100);
    checkOutput("swap1_s100", rd_side, 0);
    readAt(101, 0);
    checkOutput("swap1_s101", rd_side, 1);
    readAt(639, 0);
    checkOutput("swap1_h639", rd_height, 157);

    $display("[TB] short frame is refused");
    applyStimulus(0, 638, -1, 1);
    pulseSwap();
    checkOutput("short_front", front_bank, 1);
    checkOutput("short_dropped", dropped_frames, 1);
    readAt(100, 0);
    checkOutput("short_old_h100", rd_height, 100);

    $display("[TB] skipped column and out-of-range column");
    applyStimulus(0, 639, 300, 1);
    pulseSwap();
    checkOutput("skip_front", front_bank, 1);
    checkOutput("skip_dropped", dropped_frames, 2);
    applyStimulus(700, 700, -1, 0);
    applyStimulus(0, 639, -1, 1);
    pulseSwap();
    checkOutput("oor_front", front_bank, 1);
    checkOutput("oor_dropped", dropped_frames, 3);
    applyStimulus(0, 639, -1, 1);
    pulseSwap();
    checkOutput("clean_front", front_bank, 0);
    checkOutput("clean_dropped", dropped_frames, 3);
    readAt(100, 0);
    checkOutput("clean_h100", rd_height, 101);
    readAt(700, 0);
    checkOutput("oor_read_h", rd_height, 0);

    $display("[TB] wall window for height 40 and height 0");
    readAt(39, 199);
    checkOutput("wall_h40", rd_height, 40);
    checkOutput("wall_r199", rd_wall, 0);
    readAt(39, 200);
    checkOutput("wall_r200", rd_wall, 1);
    readAt(39, 279);
    checkOutput("wall_r279", rd_wall, 1);
    readAt(39, 280);
    checkOutput("wall_r280", rd_wall, 0);
    readAt(240, 240);
    checkOutput("wall_h0_h", rd_height, 0);
    checkOutput("wall_h0_r240", rd_wall, 0);
    readAt(240, 0);
    checkOutput("wall_h0_r0", rd_wall, 0);

    $display("[TB] final column and swap in the same cycle");
    applyStimulus(0, 638, -1, 2);
    rd_col     = COL_W'(639);
    wr_en      = 1'b1;
    wr_col     = COL_W'(639);
    wr_side    = 1'b1;
    wr_height  = HW'(159);
    frame_swap = 1'b1;
    step();
    wr_en      = 1'b0;
    frame_swap = 1'b0;
    checkOutput("same_front", front_bank, 1);
    checkOutput("same_dropped", dropped_frames, 3);
    checkOutput("same_prev_h639", rd_height, 158);
    readAt(639, 0);
    checkOutput("same_new_h639", rd_height, 159);
    checkOutput("same_new_s639", rd_side, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 100, -1, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst2_valid", frame_valid, 0);
    checkOutput("rst2_front", front_bank, 0);
    readAt(50, 240);
    checkOutput("rst2_rd_h", rd_height, 0);
    pulseSwap();
    checkOutput("rst2_swap_refused", dropped_frames, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
